// File: rtl/bmp_pkg.sv
// Shared types and header constants for the BMP byte-stream writer.
// hdr_byte() yields one byte of the 54-byte BMP file + DIB header.
package bmp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PIXELS,
        PAD,
        DONE
    } state_t;

    localparam int BMP_HDR_LEN = 54;
    localparam int BMP_DIB_LEN = 40;
    localparam int BMP_BPP     = 24;

    function automatic logic [7:0] le_byte(input logic [31:0] value, input logic [1:0] lane);
        return value[8*lane +: 8];
    endfunction

    function automatic logic [7:0] hdr_byte(
        input logic [5:0]  idx,
        input int unsigned width,
        input int unsigned height
    );
        int unsigned row_bytes;
        int unsigned pad_bytes;
        int unsigned img_size;
        int unsigned file_size;
        logic [7:0]  b;
        row_bytes = 3 * width;
        pad_bytes = (4 - row_bytes % 4) % 4;
        img_size  = (row_bytes + pad_bytes) * height;
        file_size = img_size + BMP_HDR_LEN;
        b = 8'h00;
        case (idx) inside
            6'd0:            b = 8'h42;
            6'd1:            b = 8'h4D;
            [6'd2:6'd5]:     b = le_byte(file_size, 2'(idx - 6'd2));
            [6'd10:6'd13]:   b = le_byte(32'(BMP_HDR_LEN), 2'(idx - 6'd10));
            [6'd14:6'd17]:   b = le_byte(32'(BMP_DIB_LEN), 2'(idx - 6'd14));
            [6'd18:6'd21]:   b = le_byte(width, 2'(idx - 6'd18));
            [6'd22:6'd25]:   b = le_byte(height, 2'(idx - 6'd22));
            [6'd26:6'd27]:   b = le_byte(32'd1, 2'(idx - 6'd26));
            [6'd28:6'd29]:   b = le_byte(32'(BMP_BPP), 2'(idx - 6'd28));
            [6'd34:6'd37]:   b = le_byte(img_size, 2'(idx - 6'd34));
            default:         b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bmp_stream_writer_if.sv
// Pixel-in / byte-out handshake bundle for bmp_stream_writer.
// slave is the writer itself; master is the upstream/downstream environment.
interface bmp_stream_writer_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic       frame_done;

    modport master (
        output start, in_valid, red, green, blue, out_ready,
        input  in_ready, out_valid, out_byte, out_last, frame_done
    );

    modport slave (
        input  start, in_valid, red, green, blue, out_ready,
        output in_ready, out_valid, out_byte, out_last, frame_done
    );
endinterface

// File: rtl/bmp_header_rom.sv
// Combinational lookup of the BMP header byte selected by idx.
// The table is folded to constants at elaboration from WIDTH/HEIGHT.
module bmp_header_rom
    import bmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 855,
    parameter int unsigned HEIGHT = 768
) (
    input  logic [5:0] idx,
    output logic [7:0] data
);

    logic [7:0] rom [64];

    for (genvar gi = 0; gi < 64; gi++) begin : g_rom
        assign rom[gi] = hdr_byte(6'(gi), WIDTH, HEIGHT);
    end

    assign data = rom[idx];

endmodule

// File: rtl/bmp_stream_writer.sv
// Serialises an RGB pixel stream into a 24-bit BMP byte stream (BGR, rows padded to 4 bytes).
// Define BMP_HEADER_EN to prepend the 54-byte header; otherwise raw padded pixel data is emitted.
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 855,
    parameter int unsigned HEIGHT = 768
) (
    input logic                 clk,
    input logic                 reset,
    bmp_stream_writer_if.slave  bus
);

    localparam int unsigned ROW_BYTES = 3 * WIDTH;
    localparam int unsigned PAD_BYTES = (4 - ROW_BYTES % 4) % 4;
    localparam logic        HAS_PAD   = (PAD_BYTES != 0);
    localparam logic [1:0]  PAD_N     = 2'(PAD_BYTES);
    localparam logic [1:0]  PAD_LAST  = 2'(PAD_BYTES - 1);
    localparam logic [10:0] COL_LAST  = 11'(WIDTH - 1);
    localparam logic [9:0]  ROW_LAST  = 10'(HEIGHT - 1);

    state_t      state_reg, state_next;
    logic [10:0] col_reg, col_next;
    logic [9:0]  row_reg, row_next;
    logic [1:0]  phase_reg, phase_next;
    logic [1:0]  pad_reg, pad_next;
    logic [23:0] pix_reg, pix_next;
    logic        pix_full_reg, pix_full_next;
    logic [7:0]  out_byte_reg, out_byte_next;
    logic        out_valid_reg, out_valid_next;
    logic        out_last_reg, out_last_next;
    logic        frame_done_reg, frame_done_next;

    logic xfer, out_free, last_col, last_row, red_xfer, in_ready, pix_take;

`ifdef BMP_HEADER_EN
    localparam state_t START_STATE = HEADER;
    logic [5:0] hdr_idx_reg, hdr_idx_next;
    logic [7:0] hdr_data;

    bmp_header_rom #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_header_rom (
        .idx  (hdr_idx_reg),
        .data (hdr_data)
    );
`else
    localparam state_t START_STATE = PIXELS;
`endif

    assign xfer     = out_valid_reg && bus.out_ready;
    assign out_free = !out_valid_reg || bus.out_ready;
    assign last_col = (col_reg == COL_LAST);
    assign last_row = (row_reg == ROW_LAST);
    // phase 3 means the red byte sits in the output register; the pixel slot frees when it leaves
    assign red_xfer = (state_reg == PIXELS) && pix_full_reg && (phase_reg == 2'd3) && xfer;
    assign in_ready = (state_reg == PIXELS) &&
                      (!pix_full_reg || (red_xfer && !(last_col && last_row)));
    assign pix_take = bus.in_valid && in_ready;

    always_comb begin
        state_next      = state_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        phase_next      = phase_reg;
        pad_next        = pad_reg;
        pix_next        = pix_reg;
        pix_full_next   = pix_full_reg;
        out_byte_next   = out_byte_reg;
        out_valid_next  = out_valid_reg;
        out_last_next   = out_last_reg;
        frame_done_next = frame_done_reg;
`ifdef BMP_HEADER_EN
        hdr_idx_next    = hdr_idx_reg;
`endif

        if (xfer) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end
        if (pix_take) begin
            pix_next      = {bus.red, bus.green, bus.blue};
            pix_full_next = 1'b1;
        end

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next      = START_STATE;
                    frame_done_next = 1'b0;
                    col_next        = '0;
                    row_next        = '0;
                    phase_next      = '0;
                    pad_next        = '0;
                    pix_full_next   = 1'b0;
`ifdef BMP_HEADER_EN
                    hdr_idx_next    = '0;
`endif
                end
            end
`ifdef BMP_HEADER_EN
            HEADER: begin
                if (hdr_idx_reg != 6'(BMP_HDR_LEN)) begin
                    if (out_free) begin
                        out_byte_next  = hdr_data;
                        out_valid_next = 1'b1;
                        hdr_idx_next   = hdr_idx_reg + 6'd1;
                    end
                end else if (xfer) begin
                    state_next = PIXELS;
                end
            end
`endif
            PIXELS: begin
                if (red_xfer) begin
                    phase_next    = 2'd0;
                    pix_full_next = pix_take;
                    if (!last_col) begin
                        col_next = col_reg + 11'd1;
                    end else begin
                        col_next = '0;
                        if (HAS_PAD) begin
                            state_next = PAD;
                            pad_next   = '0;
                        end else if (last_row) begin
                            state_next      = DONE;
                            frame_done_next = 1'b1;
                        end else begin
                            row_next = row_reg + 10'd1;
                        end
                    end
                    // Bypass the fresh pixel's blue byte straight out to keep one pixel per 3 cycles
                    if (pix_take && (!last_col || !HAS_PAD)) begin
                        out_byte_next  = bus.blue;
                        out_valid_next = 1'b1;
                        phase_next     = 2'd1;
                    end
                end else if (pix_full_reg && (phase_reg != 2'd3) && out_free) begin
                    case (phase_reg)
                        2'd0:    out_byte_next = pix_reg[7:0];
                        2'd1:    out_byte_next = pix_reg[15:8];
                        default: out_byte_next = pix_reg[23:16];
                    endcase
                    out_valid_next = 1'b1;
                    out_last_next  = (phase_reg == 2'd2) && !HAS_PAD && last_col && last_row;
                    phase_next     = phase_reg + 2'd1;
                end
            end
            PAD: begin
                if (pad_reg != PAD_N) begin
                    if (out_free) begin
                        out_byte_next  = 8'h00;
                        out_valid_next = 1'b1;
                        out_last_next  = last_row && (pad_reg == PAD_LAST);
                        pad_next       = pad_reg + 2'd1;
                    end
                end else if (xfer) begin
                    pad_next = '0;
                    if (last_row) begin
                        state_next      = DONE;
                        frame_done_next = 1'b1;
                    end else begin
                        row_next   = row_reg + 10'd1;
                        state_next = PIXELS;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            phase_reg      <= '0;
            pad_reg        <= '0;
            pix_reg        <= '0;
            pix_full_reg   <= 1'b0;
            out_byte_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
`ifdef BMP_HEADER_EN
            hdr_idx_reg    <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            phase_reg      <= phase_next;
            pad_reg        <= pad_next;
            pix_reg        <= pix_next;
            pix_full_reg   <= pix_full_next;
            out_byte_reg   <= out_byte_next;
            out_valid_reg  <= out_valid_next;
            out_last_reg   <= out_last_next;
            frame_done_reg <= frame_done_next;
`ifdef BMP_HEADER_EN
            hdr_idx_reg    <= hdr_idx_next;
`endif
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_byte   = out_byte_reg;
    assign bus.out_last   = out_last_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Self-checking bench for bmp_stream_writer: three geometries (pad 2, 0, 1) with random pixels and handshakes.
// Expected byte streams come from a file-format model; BMP_HEADER_EN selects header or raw output.
module tb_bmp_stream_writer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bmp_stream_writer_if bus0 ();
    bmp_stream_writer_if bus1 ();
    bmp_stream_writer_if bus2 ();

    bmp_stream_writer #(.WIDTH(2), .HEIGHT(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    bmp_stream_writer #(.WIDTH(4), .HEIGHT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    bmp_stream_writer #(.WIDTH(5), .HEIGHT(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int          sel = 0;
    logic        start_d = 1'b0;
    logic        in_valid_d = 1'b0;
    logic        out_ready_d = 1'b0;
    logic [23:0] pix_d = '0;

    assign bus0.start = start_d && (sel == 0);
    assign bus1.start = start_d && (sel == 1);
    assign bus2.start = start_d && (sel == 2);
    assign bus0.in_valid = in_valid_d && (sel == 0);
    assign bus1.in_valid = in_valid_d && (sel == 1);
    assign bus2.in_valid = in_valid_d && (sel == 2);
    assign bus0.out_ready = out_ready_d && (sel == 0);
    assign bus1.out_ready = out_ready_d && (sel == 1);
    assign bus2.out_ready = out_ready_d && (sel == 2);
    assign {bus0.red, bus0.green, bus0.blue} = pix_d;
    assign {bus1.red, bus1.green, bus1.blue} = pix_d;
    assign {bus2.red, bus2.green, bus2.blue} = pix_d;

    logic       obs_valid, obs_last, obs_in_ready, obs_done;
    logic [7:0] obs_byte;

    always_comb begin
        obs_valid = bus0.out_valid;  obs_last = bus0.out_last;  obs_byte = bus0.out_byte;
        obs_in_ready = bus0.in_ready; obs_done = bus0.frame_done;
        if (sel == 1) begin
            obs_valid = bus1.out_valid;  obs_last = bus1.out_last;  obs_byte = bus1.out_byte;
            obs_in_ready = bus1.in_ready; obs_done = bus1.frame_done;
        end else if (sel == 2) begin
            obs_valid = bus2.out_valid;  obs_last = bus2.out_last;  obs_byte = bus2.out_byte;
            obs_in_ready = bus2.in_ready; obs_done = bus2.frame_done;
        end
    end

`ifdef BMP_HEADER_EN
    localparam int HDR = 54;
`else
    localparam int HDR = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];
    logic [23:0] pix_q [$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_le(input int unsigned value, input int nbytes);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(8'(value >> (8 * i)));
    endtask

    // File-format model: header fields, then rows of BGR triples, each row zero-padded to 4 bytes
    task automatic build_expected(input int w, input int h);
        int rowb, pad, img;
        logic [23:0] p;
        rowb = 3 * w;
        pad  = (4 - rowb % 4) % 4;
        img  = (rowb + pad) * h;
        exp_q.delete();
`ifdef BMP_HEADER_EN
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push_le(img + 54, 4);
        push_le(0, 4);
        push_le(54, 4);
        push_le(40, 4);
        push_le(w, 4);
        push_le(h, 4);
        push_le(1, 2);
        push_le(24, 2);
        push_le(0, 4);
        push_le(img, 4);
        push_le(0, 16);
`endif
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                p = pix_q[r * w + c];
                exp_q.push_back(p[7:0]);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[23:16]);
            end
            for (int k = 0; k < pad; k++) exp_q.push_back(8'h00);
        end
    endtask

    task automatic run_frame(input int s, input int w, input int h, input bit fresh,
                             input bit fixed_first, input int reset_back);
        int n, np, idx, pi, cyc, stall, reset_at;
        bit mid, need_new, stall_now;
        sel = s;
        if (fresh) begin
            pix_q.delete();
            for (int i = 0; i < w * h; i++) pix_q.push_back(24'($urandom));
            if (fixed_first) pix_q[0] = 24'h112233;
        end
        build_expected(w, h);
        n  = exp_q.size();
        np = w * h;
        reset_at = (reset_back > 0) ? n - reset_back : -1;

        @(negedge clk);
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        #1;
        check($sformatf("s%0d frame_done_cleared", s), obs_done, 0);

        idx = 0; pi = 0; cyc = 0; stall = 0; mid = 0; need_new = 1;
        while (idx < n && cyc < 4000) begin
            if (idx == reset_at) break;
            stall_now = 0;
            if (obs_valid && idx == HDR + 2 && stall < 5) begin
                out_ready_d = 1'b0;
                stall++;
                stall_now = 1;
            end else begin
                out_ready_d = ($urandom_range(0, 3) != 0);
            end
            start_d = (!mid && idx == n / 3);
            if (start_d) mid = 1;
            if (need_new) begin
                if (pi < np) begin
                    in_valid_d = ($urandom_range(0, 3) != 0);
                    pix_d      = pix_q[pi];
                end else begin
                    in_valid_d = 1'b0;
                end
            end
            #1;
            if (stall_now) begin
                check($sformatf("s%0d stall_byte", s), obs_byte, exp_q[HDR + 2]);
                check($sformatf("s%0d stall_valid", s), obs_valid, 1);
                check($sformatf("s%0d stall_in_ready", s), obs_in_ready, 0);
            end
`ifdef BMP_HEADER_EN
            if (idx < HDR) check($sformatf("s%0d hdr_in_ready", s), obs_in_ready, 0);
`endif
            if (obs_valid && out_ready_d) begin
                check($sformatf("s%0d byte%0d", s, idx), obs_byte, exp_q[idx]);
                check($sformatf("s%0d last%0d", s, idx), obs_last, (idx == n - 1));
                idx++;
            end
            if (in_valid_d && obs_in_ready) begin
                pi++;
                need_new = 1;
            end else begin
                need_new = !in_valid_d;
            end
            @(negedge clk);
            cyc++;
        end
        start_d = 1'b0;
        in_valid_d = 1'b0;
        out_ready_d = 1'b0;

        if (reset_at >= 0) begin
            check($sformatf("s%0d bytes_before_reset", s), idx, reset_at);
            reset = 1'b1;
            #1;
            check($sformatf("s%0d rst_out_valid", s), obs_valid, 0);
            check($sformatf("s%0d rst_out_last", s), obs_last, 0);
            check($sformatf("s%0d rst_in_ready", s), obs_in_ready, 0);
            @(negedge clk);
            reset = 1'b0;
        end else begin
            check($sformatf("s%0d frame_len", s), idx, n);
            #1;
            check($sformatf("s%0d frame_done", s), obs_done, 1);
            check($sformatf("s%0d done_out_valid", s), obs_valid, 0);
            check($sformatf("s%0d done_in_ready", s), obs_in_ready, 0);
        end
        $display("frame sel=%0d %0dx%0d: %0d of %0d bytes in %0d cycles", s, w, h, idx, n, cyc);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            in_valid_d = 1'b1;
            #1;
            check($sformatf("s%0d reset_out_valid", s), obs_valid, 0);
            check($sformatf("s%0d reset_out_byte", s), obs_byte, 0);
            check($sformatf("s%0d reset_out_last", s), obs_last, 0);
            check($sformatf("s%0d reset_in_ready", s), obs_in_ready, 0);
            check($sformatf("s%0d reset_frame_done", s), obs_done, 0);
        end
        in_valid_d = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_in_ready", obs_in_ready, 0);

        run_frame(0, 2, 2, 1'b1, 1'b1, 10);
        run_frame(0, 2, 2, 1'b0, 1'b0, 0);
        run_frame(0, 2, 2, 1'b1, 1'b0, 0);
        run_frame(1, 4, 1, 1'b1, 1'b0, 0);
        run_frame(2, 5, 3, 1'b1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bmp_stream_writer.md
Name: bmp_stream_writer

Overview:
- Downstream sink for the per-pixel RGB stream from the image read/process stage.
- Serialises each frame into a 24-bit BMP byte stream: 54-byte header, BGR pixel bytes, and zero padding that brings each row to a 4-byte boundary.
- Output is one byte per cycle on a valid/ready interface, feeding the file-dump/testbench writer or a DMA byte port.
- Rows are emitted in arrival order; any row reordering is done upstream.

Parameters:
- WIDTH, 855, pixels per row (1..2047)
- HEIGHT, 768, rows per frame (1..1023)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a frame when in IDLE or DONE, ignored otherwise
- in_valid  input  1  upstream pixel valid
- in_ready  output  1  block can accept a pixel this cycle
- red  input  8  pixel red
- green  input  8  pixel green
- blue  input  8  pixel blue
- out_valid  output  1  out_byte is valid
- out_ready  input  1  downstream accepts out_byte
- out_byte  output  8  serialised BMP byte
- out_last  output  1  high with the final byte of the frame
- frame_done  output  1  sticky; set after the last byte transfers, cleared by start

Behaviour:
- Reset: state=IDLE; out_valid=0, out_byte=0, out_last=0, in_ready=0, frame_done=0; all counters 0.
- Reset asserted mid-frame aborts the frame immediately; no partial flush.
- Derived constants:
  - ROWB = 3*WIDTH
  - PAD = (4 - ROWB%4)%4
  - IMGSZ = (ROWB+PAD)*HEIGHT
  - FILESZ = IMGSZ+54
- States: IDLE, HEADER, PIXELS, PAD, DONE.
- IDLE/DONE + start -> HEADER. Entering HEADER clears frame_done and hdr_idx.
- HEADER:
  - Emits bytes 0..53 in order, all multi-byte fields little-endian: 'B','M'; FILESZ(4); 0(4); 54(4); 40(4); WIDTH(4); HEIGHT(4); 1(2); 24(2); 0(4); IMGSZ(4); 0(16).
  - After byte 53 transfers -> PIXELS.
- PIXELS:
  - Pixel register loads {r,g,b} on in_valid && in_ready.
  - Bytes are emitted in order blue, green, red (phase 0,1,2).
  - in_ready=1 only in PIXELS when the pixel register is empty, or when its red byte transfers this cycle.
  - Sustained rate is one pixel every 3 cycles with out_ready held high.
  - After the red byte of column WIDTH-1 transfers: if PAD>0 -> PAD, else next row (or DONE if the row is HEIGHT-1).
- PAD: emits PAD bytes of 0x00, then -> PIXELS (next row), or -> DONE after row HEIGHT-1.
- Output register rules:
  - out_byte/out_valid are registered; first byte appears the cycle after HEADER entry.
  - A byte transfers on out_valid && out_ready.
  - While out_ready=0, out_byte, out_valid and out_last hold stable.
  - out_valid must not drop without a transfer.
- out_last is set with the final byte: the last pad byte, or the red byte of the last pixel when PAD=0.
- On that byte's transfer: frame_done<=1, state DONE, out_valid<=0.
- in_valid while not in PIXELS is ignored (in_ready=0); the upstream holds the pixel.
- start during HEADER/PIXELS/PAD is ignored.
- Counter widths: col 11 bits, row 10 bits, hdr_idx 6 bits, phase 2 bits, pad 2 bits. FILESZ is computed as a 32-bit constant.

Optional Feature:
- Macro BMP_HEADER_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - HEADER state and header logic are removed; start goes directly to PIXELS.
  - Stream is raw padded pixel data, IMGSZ bytes total.
  - out_last marks byte IMGSZ-1.

Decomposition:
- Package bmp_pkg holds:
  - state enum (IDLE, HEADER, PIXELS, PAD, DONE)
  - BMP_HDR_LEN=54, BMP_DIB_LEN=40, BMP_BPP=24
  - function hdr_byte(idx, width, height) returning header byte idx.
- One sub-module, bmp_header_rom: combinational byte lookup from hdr_idx using the package function.
- All sequencing stays in bmp_stream_writer.

Test Plan:
- WIDTH=2, HEIGHT=2, out_ready=1, start pulse -> 70 bytes total:
  - bytes 0..1 = 0x42,0x4D
  - bytes 2..5 = 0x46,0,0,0
  - bytes 34..37 = 0x10,0,0,0
  - out_last only on byte 69; frame_done=1 next cycle.
- Pixel r=0x11,g=0x22,b=0x33 as first pixel -> bytes 54,55,56 = 0x33,0x22,0x11; bytes 60,61 = 0x00 (PAD=2).
- WIDTH=4, HEIGHT=1 (PAD=0) -> no pad bytes; red byte of pixel 3 carries out_last; 66 bytes total.
- out_ready held low 5 cycles at byte 56 -> out_byte stays 0x11, out_valid stays 1; in_ready=0 until released; no byte lost or duplicated.
- reset pulsed after 60 bytes -> out_valid=0 and state IDLE immediately; a new start reproduces the identical 70-byte stream.
- BMP_HEADER_EN undefined, WIDTH=2, HEIGHT=2 -> first byte is pixel-0 blue; 16 bytes total; out_last on byte 15.
